// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of every signal between the memory arbiter, the two
// caches and the main-memory model.
//
// Handshake (request/ready, level-sensitive):
//   A cache raises its enable(s) with addr/write_data and holds them stable
//   until its one-cycle ready pulse. The arbiter raises out_mem_read_en or
//   out_mem_write_en and holds it with out_mem_addr/out_mem_write_data until
//   memory answers with in_mem_ready. Read data is valid with in_mem_ready.
//
// Ports (signals), grouped by peer:
//   I-cache : in_i_read_en, in_i_addr, out_i_read_data, out_i_ready
//   D-cache : in_d_read_en, in_d_write_en, in_d_addr, in_d_write_data,
//             out_d_read_data, out_d_ready
//   memory  : out_mem_read_en, out_mem_write_en, out_mem_addr,
//             out_mem_write_data, in_mem_read_data, in_mem_ready
//   status  : out_busy, out_grant_d
// Modports: slave = arbiter view, master = environment (caches + memory) view.
interface mem_arbiter_if #(
   parameter int CACHE_LINE_SIZE = 128,
   parameter int ADDR_WIDTH      = 32
);
   logic                       in_i_read_en;
   logic [ADDR_WIDTH-1:0]      in_i_addr;
   logic [CACHE_LINE_SIZE-1:0] out_i_read_data;
   logic                       out_i_ready;

   logic                       in_d_read_en;
   logic                       in_d_write_en;
   logic [ADDR_WIDTH-1:0]      in_d_addr;
   logic [CACHE_LINE_SIZE-1:0] in_d_write_data;
   logic [CACHE_LINE_SIZE-1:0] out_d_read_data;
   logic                       out_d_ready;

   logic                       out_mem_read_en;
   logic                       out_mem_write_en;
   logic [ADDR_WIDTH-1:0]      out_mem_addr;
   logic [CACHE_LINE_SIZE-1:0] out_mem_write_data;
   logic [CACHE_LINE_SIZE-1:0] in_mem_read_data;
   logic                       in_mem_ready;

   logic                       out_busy;
   logic                       out_grant_d;

   modport slave (
      input  in_i_read_en, in_i_addr,
      output out_i_read_data, out_i_ready,
      input  in_d_read_en, in_d_write_en, in_d_addr, in_d_write_data,
      output out_d_read_data, out_d_ready,
      output out_mem_read_en, out_mem_write_en, out_mem_addr, out_mem_write_data,
      input  in_mem_read_data, in_mem_ready,
      output out_busy, out_grant_d
   );

   modport master (
      output in_i_read_en, in_i_addr,
      input  out_i_read_data, out_i_ready,
      output in_d_read_en, in_d_write_en, in_d_addr, in_d_write_data,
      input  out_d_read_data, out_d_ready,
      input  out_mem_read_en, out_mem_write_en, out_mem_addr, out_mem_write_data,
      output in_mem_read_data, in_mem_ready,
      input  out_busy, out_grant_d
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-wide main-memory port between the I-cache and
// the D-cache. One transaction at a time: IDLE picks a winner and latches its
// operands, MEM holds the memory strobe until in_mem_ready, DONE pulses the
// owner's ready for one cycle so it can drop its request before re-arbitration.
//
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous, active-low reset
//   bus       : mem_arbiter_if.slave, all cache/memory/status signals
//   dbg_state : current FSM state (0 IDLE, 1 MEM, 2 DONE)
//
// Build option: define MEM_ARB_ROUND_ROBIN_EN to replace fixed D-over-I
// priority with a last-owner pointer that alternates on simultaneous requests.
module mem_arbiter #(
   parameter int CACHE_LINE_SIZE = 128,
   parameter int ADDR_WIDTH      = 32
) (
   input  logic         clk,
   input  logic         reset,
   mem_arbiter_if.slave bus,
   output logic [1:0]   dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MEM  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                     state;
   logic                       grant_d;
   logic                       busy;
   logic                       mem_read_en;
   logic                       mem_write_en;
   logic [ADDR_WIDTH-1:0]      mem_addr;
   logic [CACHE_LINE_SIZE-1:0] mem_write_data;
   logic [CACHE_LINE_SIZE-1:0] i_read_data;
   logic [CACHE_LINE_SIZE-1:0] d_read_data;
   logic                       i_ready;
   logic                       d_ready;

   logic d_req;
   logic i_req;
   logic win_d;
   logic win_write;

   assign d_req = bus.in_d_read_en | bus.in_d_write_en;
   assign i_req = bus.in_i_read_en;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // Last owner: 1 = D. Reset value 0 means D wins the first contest.
   logic last_d;

   // On a tie, the side that did not win last time gets the grant.
   assign win_d = d_req & (~i_req | ~last_d);

   always_ff @(posedge clk) begin
      if (!reset) begin
         last_d <= 1'b0;
      end else if (state == IDLE && (d_req || i_req)) begin
         last_d <= win_d;
      end
   end
`else
   assign win_d = d_req;
`endif

   // read_en together with write_en from D counts as a writeback.
   assign win_write = win_d & bus.in_d_write_en;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= IDLE;
         grant_d        <= 1'b0;
         busy           <= 1'b0;
         mem_read_en    <= 1'b0;
         mem_write_en   <= 1'b0;
         mem_addr       <= '0;
         mem_write_data <= '0;
         i_read_data    <= '0;
         d_read_data    <= '0;
         i_ready        <= 1'b0;
         d_ready        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (d_req || i_req) begin
                  state        <= MEM;
                  busy         <= 1'b1;
                  grant_d      <= win_d;
                  mem_read_en  <= ~win_write;
                  mem_write_en <= win_write;
                  if (win_d) begin
                     mem_addr       <= bus.in_d_addr;
                     mem_write_data <= bus.in_d_write_data;
                  end else begin
                     mem_addr       <= bus.in_i_addr;
                     mem_write_data <= '0;
                  end
               end
            end

            MEM: begin
               if (bus.in_mem_ready) begin
                  state        <= DONE;
                  mem_read_en  <= 1'b0;
                  mem_write_en <= 1'b0;
                  // The strobe still reflects the op, so it selects the capture.
                  if (mem_read_en) begin
                     if (grant_d) d_read_data <= bus.in_mem_read_data;
                     else         i_read_data <= bus.in_mem_read_data;
                  end
                  if (grant_d) d_ready <= 1'b1;
                  else         i_ready <= 1'b1;
               end
            end

            DONE: begin
               state   <= IDLE;
               busy    <= 1'b0;
               i_ready <= 1'b0;
               d_ready <= 1'b0;
            end

            default: begin
               state        <= IDLE;
               busy         <= 1'b0;
               mem_read_en  <= 1'b0;
               mem_write_en <= 1'b0;
               i_ready      <= 1'b0;
               d_ready      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.out_i_read_data    = i_read_data;
   assign bus.out_i_ready        = i_ready;
   assign bus.out_d_read_data    = d_read_data;
   assign bus.out_d_ready        = d_ready;
   assign bus.out_mem_read_en    = mem_read_en;
   assign bus.out_mem_write_en   = mem_write_en;
   assign bus.out_mem_addr       = mem_addr;
   assign bus.out_mem_write_data = mem_write_data;
   assign bus.out_busy           = busy;
   assign bus.out_grant_d        = grant_d;
   assign dbg_state              = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. Inputs are driven 1 time
// unit after a rising edge and outputs are checked at the same point, so each
// check sees the registers loaded by the edge just passed.
module tb_mem_arbiter;

   localparam int LW = 128;
   localparam int AW = 32;

   logic       clk;
   logic       reset;
   logic [1:0] dbg_state;

   int checks = 0;
   int errors = 0;

   mem_arbiter_if #(.CACHE_LINE_SIZE(LW), .ADDR_WIDTH(AW)) bus ();

   mem_arbiter #(.CACHE_LINE_SIZE(LW), .ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [LW-1:0] line1, line2, line3, line4, line5, line6, wline, junk;
   logic [LW-1:0] rr_line [4];
   logic          exp_gd  [4];

   initial begin
      line1 = {4{32'hDEADBEEF}};
      line2 = {4{32'h2222_0002}};
      line3 = {4{32'h3333_0003}};
      line4 = {4{32'h4444_0004}};
      line5 = {4{32'h5555_0005}};
      line6 = {4{32'h6666_0006}};
      wline = {4{32'h1111_1111}};
      junk  = {4{32'h0BAD_F00D}};
      rr_line[0] = {4{32'hA000_0000}};
      rr_line[1] = {4{32'hA111_1111}};
      rr_line[2] = {4{32'hA222_2222}};
      rr_line[3] = {4{32'hA333_3333}};
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_gd[0] = 1'b1; exp_gd[1] = 1'b0; exp_gd[2] = 1'b1; exp_gd[3] = 1'b0;
`else
      exp_gd[0] = 1'b1; exp_gd[1] = 1'b1; exp_gd[2] = 1'b1; exp_gd[3] = 1'b1;
`endif

      // reset
      reset = 1'b0;
      bus.in_i_read_en     = 1'b0;
      bus.in_i_addr        = '0;
      bus.in_d_read_en     = 1'b0;
      bus.in_d_write_en    = 1'b0;
      bus.in_d_addr        = '0;
      bus.in_d_write_data  = '0;
      bus.in_mem_read_data = '0;
      bus.in_mem_ready     = 1'b0;
      tick();
      tick();
      check("rst_rd_en", bus.out_mem_read_en, 0);
      check("rst_wr_en", bus.out_mem_write_en, 0);
      check("rst_busy", bus.out_busy, 0);
      check("rst_grant", bus.out_grant_d, 0);
      check("rst_addr", bus.out_mem_addr, 0);
      check("rst_i_rdata", bus.out_i_read_data, 0);
      check("rst_d_rdata", bus.out_d_read_data, 0);
      check("rst_state", dbg_state, 0);
      reset = 1'b1;
      tick();

      // 1. I read, memory answers in the 5th strobe cycle
      bus.in_i_read_en = 1'b1;
      bus.in_i_addr    = 32'h0000_1000;
      tick();
      check("t1_rd_en", bus.out_mem_read_en, 1);
      check("t1_wr_en", bus.out_mem_write_en, 0);
      check("t1_addr", bus.out_mem_addr, 32'h1000);
      check("t1_grant", bus.out_grant_d, 0);
      check("t1_busy", bus.out_busy, 1);
      check("t1_state", dbg_state, 1);
      for (int c = 0; c < 4; c++) begin
         tick();
         check("t1_rd_hold", bus.out_mem_read_en, 1);
         check("t1_i_rdy_low", bus.out_i_ready, 0);
      end
      bus.in_mem_ready     = 1'b1;
      bus.in_mem_read_data = line1;
      tick();
      check("t1_i_rdy", bus.out_i_ready, 1);
      check("t1_i_rdata", bus.out_i_read_data, line1);
      check("t1_d_rdy", bus.out_d_ready, 0);
      check("t1_rd_drop", bus.out_mem_read_en, 0);
      check("t1_state_done", dbg_state, 2);
      bus.in_mem_ready = 1'b0;
      bus.in_i_read_en = 1'b0;
      tick();
      check("t1_i_rdy_once", bus.out_i_ready, 0);
      check("t1_idle_busy", bus.out_busy, 0);

      // 2. D writeback (read data on the bus must not be captured)
      bus.in_d_write_en   = 1'b1;
      bus.in_d_addr       = 32'h0000_2000;
      bus.in_d_write_data = wline;
      tick();
      check("t2_wr_en", bus.out_mem_write_en, 1);
      check("t2_rd_en", bus.out_mem_read_en, 0);
      check("t2_addr", bus.out_mem_addr, 32'h2000);
      check("t2_wdata", bus.out_mem_write_data, wline);
      check("t2_grant", bus.out_grant_d, 1);
      for (int c = 0; c < 2; c++) begin
         tick();
         check("t2_wr_hold", bus.out_mem_write_en, 1);
         check("t2_rd_low", bus.out_mem_read_en, 0);
      end
      bus.in_mem_ready     = 1'b1;
      bus.in_mem_read_data = junk;
      tick();
      check("t2_d_rdy", bus.out_d_ready, 1);
      check("t2_i_rdy", bus.out_i_ready, 0);
      check("t2_wr_drop", bus.out_mem_write_en, 0);
      check("t2_rd_low2", bus.out_mem_read_en, 0);
      check("t2_d_rdata_hold", bus.out_d_read_data, 0);
      bus.in_mem_ready  = 1'b0;
      bus.in_d_write_en = 1'b0;
      tick();
      check("t2_d_rdy_once", bus.out_d_ready, 0);

      // stray in_mem_ready while IDLE is ignored
      bus.in_mem_ready     = 1'b1;
      bus.in_mem_read_data = junk;
      tick();
      check("idle_rdy_busy", bus.out_busy, 0);
      check("idle_rdy_i", bus.out_i_ready, 0);
      check("idle_rdy_i_rdata", bus.out_i_read_data, line1);
      bus.in_mem_ready = 1'b0;

      // 6. minimum latency: in_mem_ready in the first strobe cycle
      bus.in_i_read_en = 1'b1;
      bus.in_i_addr    = 32'h0000_9000;
      tick();
      check("t6_rd_en", bus.out_mem_read_en, 1);
      bus.in_mem_ready     = 1'b1;
      bus.in_mem_read_data = line6;
      tick();
      check("t6_i_rdy", bus.out_i_ready, 1);
      check("t6_i_rdata", bus.out_i_read_data, line6);
      check("t6_busy_done", bus.out_busy, 1);
      bus.in_mem_ready = 1'b0;
      bus.in_i_read_en = 1'b0;
      tick();
      check("t6_busy_idle", bus.out_busy, 0);
      check("t6_i_rdy_low", bus.out_i_ready, 0);

      // 5. reset two cycles into a D read, then an I read completes
      bus.in_d_read_en = 1'b1;
      bus.in_d_addr    = 32'h0000_7000;
      tick();
      tick();
      check("t5_rd_en", bus.out_mem_read_en, 1);
      check("t5_grant", bus.out_grant_d, 1);
      reset = 1'b0;
      bus.in_d_read_en = 1'b0;
      tick();
      check("t5_rd_off", bus.out_mem_read_en, 0);
      check("t5_wr_off", bus.out_mem_write_en, 0);
      check("t5_busy", bus.out_busy, 0);
      check("t5_d_rdy", bus.out_d_ready, 0);
      check("t5_state", dbg_state, 0);
      check("t5_i_rdata_clr", bus.out_i_read_data, 0);
      reset = 1'b1;
      tick();
      check("t5_d_rdy2", bus.out_d_ready, 0);
      bus.in_i_read_en = 1'b1;
      bus.in_i_addr    = 32'h0000_8000;
      tick();
      check("t5_i_rd_en", bus.out_mem_read_en, 1);
      check("t5_i_addr", bus.out_mem_addr, 32'h8000);
      bus.in_mem_ready     = 1'b1;
      bus.in_mem_read_data = line5;
      tick();
      check("t5_i_rdy", bus.out_i_ready, 1);
      check("t5_i_rdata", bus.out_i_read_data, line5);
      bus.in_mem_ready = 1'b0;
      bus.in_i_read_en = 1'b0;
      tick();

      // 3. simultaneous I and D: D first, then I
      bus.in_i_read_en = 1'b1;
      bus.in_i_addr    = 32'h0000_3000;
      bus.in_d_read_en = 1'b1;
      bus.in_d_addr    = 32'h0000_4000;
      tick();
      check("t3_grant_d", bus.out_grant_d, 1);
      check("t3_addr_d", bus.out_mem_addr, 32'h4000);
      bus.in_mem_ready     = 1'b1;
      bus.in_mem_read_data = line2;
      tick();
      check("t3_d_rdy", bus.out_d_ready, 1);
      check("t3_i_rdy", bus.out_i_ready, 0);
      check("t3_d_rdata", bus.out_d_read_data, line2);
      check("t3_i_rdata_hold", bus.out_i_read_data, line5);
      bus.in_mem_ready = 1'b0;
      bus.in_d_read_en = 1'b0;
      tick();
      check("t3_idle", bus.out_busy, 0);
      tick();
      check("t3_grant_i", bus.out_grant_d, 0);
      check("t3_addr_i", bus.out_mem_addr, 32'h3000);
      check("t3_rd_en_i", bus.out_mem_read_en, 1);
      bus.in_mem_ready     = 1'b1;
      bus.in_mem_read_data = line3;
      tick();
      check("t3_i_rdy2", bus.out_i_ready, 1);
      check("t3_i_rdata", bus.out_i_read_data, line3);
      check("t3_d_rdata_hold", bus.out_d_read_data, line2);
      bus.in_mem_ready = 1'b0;
      bus.in_i_read_en = 1'b0;
      tick();

      // 4. both requesting continuously for 4 transactions
      bus.in_i_read_en = 1'b1;
      bus.in_i_addr    = 32'h0000_5000;
      bus.in_d_read_en = 1'b1;
      bus.in_d_addr    = 32'h0000_6000;
      for (int n = 0; n < 4; n++) begin
         tick();
         check("t4_grant", bus.out_grant_d, exp_gd[n]);
         check("t4_addr", bus.out_mem_addr, exp_gd[n] ? 32'h6000 : 32'h5000);
         bus.in_mem_ready     = 1'b1;
         bus.in_mem_read_data = rr_line[n];
         tick();
         check("t4_d_rdy", bus.out_d_ready, exp_gd[n]);
         check("t4_i_rdy", bus.out_i_ready, !exp_gd[n]);
         if (exp_gd[n]) check("t4_d_rdata", bus.out_d_read_data, rr_line[n]);
         else           check("t4_i_rdata", bus.out_i_read_data, rr_line[n]);
         bus.in_mem_ready = 1'b0;
         tick();
         check("t4_idle", bus.out_busy, 0);
      end
      bus.in_i_read_en = 1'b0;
      bus.in_d_read_en = 1'b0;
      tick();
      check("end_busy", bus.out_busy, 0);
      check("end_line4_unused", bus.out_i_read_data == line4, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
